// File: rtl/vote_argmax.sv
// vote_argmax: argmax over a stream of per-class ones-counts.
// Accepts NUM_CLASSES counts per round over a valid handshake. It keeps the
// running maximum (the lowest index wins a tie) and pulses result_valid_o
// when the round is complete.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start_i; results of the last round are held
// COLLECT | accepting count beats; ready_o/busy_o high; stalls allowed
// DONE    | single-cycle result_valid_o pulse; start_i chains a round
module vote_argmax #(
  parameter  int COUNT_WIDTH = 4,
  parameter  int NUM_CLASSES = 4,
  localparam int CLASS_WIDTH = $clog2(NUM_CLASSES)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   count_valid_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
  output logic                   ready_o,
  output logic                   busy_o,
  output logic                   result_valid_o,
  output logic [CLASS_WIDTH-1:0] class_o,
  output logic [COUNT_WIDTH-1:0] max_count_o,
  output logic                   tie_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CLASS_WIDTH-1:0] LAST_BEAT = CLASS_WIDTH'(NUM_CLASSES - 1);

  state_t                 state;
  logic [CLASS_WIDTH-1:0] beat_idx;

  // Round sequencing, running max/argmax/tie and registered status outputs.
  // max_count_o is the max register itself, so the running value is visible.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state          <= IDLE;
      beat_idx       <= '0;
      ready_o        <= 1'b0;
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
      class_o        <= '0;
      max_count_o    <= '0;
      tie_o          <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state       <= COLLECT;
            ready_o     <= 1'b1;
            busy_o      <= 1'b1;
            beat_idx    <= '0;
            class_o     <= '0;
            max_count_o <= '0;
            tie_o       <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        COLLECT: begin
          if (count_valid_i) begin
            if (beat_idx == '0) begin
              max_count_o <= count_i;
              class_o     <= '0;
              tie_o       <= 1'b0;
            end else if (count_i > max_count_o) begin
              max_count_o <= count_i;
              class_o     <= beat_idx;
              tie_o       <= 1'b0;
            end else if (count_i == max_count_o) begin
              tie_o <= 1'b1;
            end
            if (beat_idx == LAST_BEAT) begin
              state          <= DONE;
              ready_o        <= 1'b0;
              busy_o         <= 1'b0;
              result_valid_o <= 1'b1;
              beat_idx       <= '0;
            end else begin
              beat_idx <= beat_idx + CLASS_WIDTH'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_argmax.sv
// tb_vote_argmax: directed rounds for vote_argmax with hand-computed results.
module tb_vote_argmax;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       count_valid_i = 1'b0;
  logic [3:0] count_i = 4'd0;
  logic       ready_o;
  logic       busy_o;
  logic       result_valid_o;
  logic [1:0] class_o;
  logic [3:0] max_count_o;
  logic       tie_o;

  int n_cmp = 0;
  int n_bad = 0;

  vote_argmax #(.COUNT_WIDTH(4), .NUM_CLASSES(4)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .count_valid_i  (count_valid_i),
    .count_i        (count_i),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .class_o        (class_o),
    .max_count_o    (max_count_o),
    .tie_o          (tie_o)
  );

  always #5 clock_i = ~clock_i;

  // Hard stop in case the bench ever stops advancing.
  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check_result(input string tag, input int cls, input int mx, input int tie);
    check({tag, ".class"}, 32'(class_o), 32'(cls));
    check({tag, ".max"},   32'(max_count_o), 32'(mx));
    check({tag, ".tie"},   32'(tie_o), 32'(tie));
  endtask

  task automatic start_round(input string tag);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, ".ready"}, 32'(ready_o), 32'd1);
    check({tag, ".busy"},  32'(busy_o), 32'd1);
    check({tag, ".clr_max"}, 32'(max_count_o), 32'd0);
  endtask

  // Feed four back-to-back beats (first count in the top nibble), check the
  // pulse timing and result, then either idle or chain a new round in DONE.
  task automatic feed(input string tag, input logic [15:0] v,
                      input int cls, input int mx, input int tie, input bit chain);
    for (int i = 0; i < 4; i++) begin
      count_valid_i = 1'b1;
      count_i = v[15-4*i -: 4];
      tick();
      if (i < 3) check({tag, ".no_early_rv"}, 32'(result_valid_o), 32'd0);
    end
    count_valid_i = 1'b0;
    check({tag, ".rv"},    32'(result_valid_o), 32'd1);
    check({tag, ".ready_done"}, 32'(ready_o), 32'd0);
    check_result(tag, cls, mx, tie);
    if (chain) begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check({tag, ".chain_rv"},   32'(result_valid_o), 32'd0);
      check({tag, ".chain_busy"}, 32'(busy_o), 32'd1);
      check({tag, ".chain_ready"}, 32'(ready_o), 32'd1);
    end else begin
      tick();
      check({tag, ".rv_one_cycle"}, 32'(result_valid_o), 32'd0);
      check({tag, ".idle_busy"},    32'(busy_o), 32'd0);
      check_result({tag, ".hold"}, cls, mx, tie);
    end
  endtask

  initial begin
    int rv_seen;
    int rdy_seen;

    // Reset, then idle with count_valid_i toggling.
    tick();
    tick();
    reset_i = 1'b0;
    check("rst.ready", 32'(ready_o), 32'd0);
    check("rst.busy",  32'(busy_o), 32'd0);
    check("rst.rv",    32'(result_valid_o), 32'd0);
    check_result("rst", 0, 0, 0);
    rv_seen = 0;
    rdy_seen = 0;
    count_i = 4'd9;
    for (int i = 0; i < 6; i++) begin
      count_valid_i = ~count_valid_i;
      tick();
      if (result_valid_o) rv_seen++;
      if (ready_o) rdy_seen++;
    end
    count_valid_i = 1'b0;
    check("idle.rv_pulses", 32'(rv_seen), 32'd0);
    check("idle.ready_seen", 32'(rdy_seen), 32'd0);
    check_result("idle", 0, 0, 0);

    // Basic round: 3,7,2,5.
    start_round("r1");
    feed("r1", 16'h3725, 1, 7, 0, 1'b0);

    // Ties: lowest index wins.
    start_round("r2");
    feed("r2", 16'h6261, 0, 6, 1, 1'b0);
    start_round("r3");
    feed("r3", 16'h1888, 1, 8, 1, 1'b0);
    start_round("r4");
    feed("r4", 16'h2584, 2, 8, 0, 1'b0);

    // Stalls and a start_i pulse mid-round: 4,0,(3 idle),1,(start),8.
    start_round("st");
    count_valid_i = 1'b1; count_i = 4'd4; tick();
    count_valid_i = 1'b1; count_i = 4'd0; tick();
    count_valid_i = 1'b0; count_i = 4'd15;
    rv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (result_valid_o) rv_seen++;
    end
    check("st.stall_ready", 32'(ready_o), 32'd1);
    check("st.stall_max",   32'(max_count_o), 32'd4);
    count_valid_i = 1'b1; count_i = 4'd1; tick();
    count_valid_i = 1'b0; start_i = 1'b1; tick();
    start_i = 1'b0;
    if (result_valid_o) rv_seen++;
    check("st.start_ignored_max", 32'(max_count_o), 32'd4);
    check("st.busy", 32'(busy_o), 32'd1);
    count_valid_i = 1'b1; count_i = 4'd8; tick();
    count_valid_i = 1'b0;
    check("st.no_early_rv", 32'(rv_seen), 32'd0);
    check("st.rv", 32'(result_valid_o), 32'd1);
    check_result("st", 3, 8, 0);
    tick();
    check("st.rv_one_cycle", 32'(result_valid_o), 32'd0);

    // Back-to-back: start in DONE, second round of all zeros.
    start_round("bb");
    feed("bb1", 16'h5512, 0, 5, 1, 1'b1);
    check("bb.cleared_max", 32'(max_count_o), 32'd0);
    check("bb.cleared_tie", 32'(tie_o), 32'd0);
    feed("bb2", 16'h0000, 0, 0, 1, 1'b0);

    // Reset after two beats aborts the round.
    start_round("ab");
    count_valid_i = 1'b1; count_i = 4'd8; tick();
    count_valid_i = 1'b1; count_i = 4'd8; tick();
    count_valid_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("ab.rv",    32'(result_valid_o), 32'd0);
    check("ab.busy",  32'(busy_o), 32'd0);
    check("ab.ready", 32'(ready_o), 32'd0);
    check_result("ab", 0, 0, 0);
    rv_seen = 0;
    count_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (result_valid_o) rv_seen++;
    end
    count_valid_i = 1'b0;
    check("ab.no_pulse", 32'(rv_seen), 32'd0);
    start_round("fr");
    feed("fr", 16'h1234, 3, 4, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
